// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: queues host writes to video memory and issues them when the renderer is idle.
// Latency: a write pushed at edge E0 strobes at earliest in the cycle after E1; one write per cycle.
// Backpressure: wr_ready drops when the FIFO is full; a write offered then is dropped and sets overflow.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   wr_valid/wr_addr/wr_data     host write request (16-bit internal address, 8-bit data)
//   wr_ready                     combinational, high while the FIFO has space
//   render_active                renderer owns the memory port this cycle
//   clear_overflow               clears the sticky overflow flag
//   *_memory_write_enable        one-hot one-cycle write strobes (tile / attribute / color)
//   memory_write_addr/data       decoded 12-bit address and data of the current write
//   render_stall                 high in the cycle of a forced (starvation-guard) write
//   pending_count                FIFO occupancy
//   overflow                     sticky dropped-write flag
module vram_write_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [15:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_ready,
   input  logic        render_active,
   input  logic        clear_overflow,
   output logic        tile_memory_write_enable,
   output logic        attribute_memory_write_enable,
   output logic        color_memory_write_enable,
   output logic [11:0] memory_write_addr,
   output logic [7:0]  memory_write_data,
   output logic        render_stall,
   output logic [4:0]  pending_count,
   output logic        overflow
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   // Keep the counter at least one bit wide so MAX_WAIT = 0 still elaborates.
   localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
   localparam logic [4:0]     DEPTH5   = 5'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_GRANT = 2'd2;

   logic [15:0]    r_addr_mem [FIFO_DEPTH];
   logic [7:0]     r_data_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [4:0]     r_count;
   logic [WCW-1:0] r_wait_cnt;
   logic [1:0]     r_state;
   logic [2:0]     r_kind;      // {tile, attr, color} of the write in flight
   logic [11:0]    r_maddr;
   logic [7:0]     r_mdata;
   logic           r_stall;
   logic           r_overflow;

   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_drop;
   logic           w_forced;
   logic           w_grant;
   logic [4:0]     w_count_nxt;
   logic [15:0]    w_head_addr;
   logic [15:0]    w_attr_off;
   logic [2:0]     w_kind;
   logic [11:0]    w_dec_addr;

   assign w_full   = (r_count == DEPTH5);
   assign w_empty  = (r_count == 5'd0);
   assign wr_ready = ~w_full;
   assign w_push   = wr_valid & ~w_full;
   assign w_drop   = wr_valid & w_full;

   // Starvation guard: only when the queue is full and the renderer has held the
   // port for MAX_WAIT consecutive full-blocked edges.
   assign w_forced = (MAX_WAIT != 0) && w_full && render_active && (r_wait_cnt == WAIT_MAX);
   assign w_grant  = ~w_empty & (~render_active | w_forced);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_grant)
         w_count_nxt = r_count + 5'd1;
      else if (!w_push && w_grant)
         w_count_nxt = r_count - 5'd1;
   end

   // Head-of-queue address decode into one of the three memories.
   assign w_head_addr = r_addr_mem[r_rptr];
   assign w_attr_off  = w_head_addr - 16'h0800;

   always_comb begin
      w_kind     = 3'b000;
      w_dec_addr = 12'h000;
      if (w_head_addr < 16'h0800) begin
         w_kind     = 3'b100;
         w_dec_addr = {1'b0, w_head_addr[10:0]};
      end else if (w_head_addr < 16'h1800) begin
         w_kind     = 3'b010;
         w_dec_addr = w_attr_off[11:0];
      end else begin
         w_kind     = 3'b001;
         w_dec_addr = {8'h00, w_head_addr[3:0]};
      end
   end

   // Storage array needs no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_mem[r_wptr] <= wr_addr;
         r_data_mem[r_wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= 5'd0;
         r_wait_cnt <= '0;
         r_state    <= S_IDLE;
         r_kind     <= 3'b000;
         r_maddr    <= 12'h000;
         r_mdata    <= 8'h00;
         r_stall    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push)
            r_wptr <= r_wptr + AW'(1);

         if (w_grant) begin
            r_rptr  <= r_rptr + AW'(1);
            r_kind  <= w_kind;
            r_maddr <= w_dec_addr;
            r_mdata <= r_data_mem[r_rptr];
            r_stall <= w_forced;
            r_state <= S_GRANT;
         end else begin
            r_kind  <= 3'b000;
            r_stall <= 1'b0;
            r_state <= (w_count_nxt != 5'd0) ? S_WAIT : S_IDLE;
         end

         // Full and not granted implies the renderer is holding the port.
         if (w_grant || !w_full)
            r_wait_cnt <= '0;
         else if (r_wait_cnt != WAIT_MAX)
            r_wait_cnt <= r_wait_cnt + WCW'(1);

         // A drop at the same edge as a clear leaves the flag set.
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_overflow)
            r_overflow <= 1'b0;
      end
   end

   // Strobes exist only in the GRANT state, so they are one cycle per grant.
   assign tile_memory_write_enable      = (r_state == S_GRANT) & r_kind[2];
   assign attribute_memory_write_enable = (r_state == S_GRANT) & r_kind[1];
   assign color_memory_write_enable     = (r_state == S_GRANT) & r_kind[0];
   assign memory_write_addr             = r_maddr;
   assign memory_write_data             = r_mdata;
   assign render_stall                  = r_stall;
   assign pending_count                 = r_count;
   assign overflow                      = r_overflow;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed vectors against hand-computed results.
// Runs a default instance (depth 4, MAX_WAIT 8) and a MAX_WAIT = 0 instance on shared stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_vram_write_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr = 16'h0;
   logic [7:0]  wr_data = 8'h0;
   logic        render_active = 1'b0;
   logic        clear_overflow = 1'b0;

   logic        wr_ready, tile_we, attr_we, color_we, render_stall, overflow;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data;
   logic [4:0]  pending;

   logic        z_ready, z_tile, z_attr, z_color, z_stall, z_ovf;
   logic [11:0] z_addr;
   logic [7:0]  z_data;
   logic [4:0]  z_pending;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vram_write_scheduler #(.FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .render_active(render_active), .clear_overflow(clear_overflow),
      .tile_memory_write_enable(tile_we), .attribute_memory_write_enable(attr_we),
      .color_memory_write_enable(color_we), .memory_write_addr(mem_addr),
      .memory_write_data(mem_data), .render_stall(render_stall),
      .pending_count(pending), .overflow(overflow)
   );

   vram_write_scheduler #(.FIFO_DEPTH(4), .MAX_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(z_ready), .render_active(render_active), .clear_overflow(clear_overflow),
      .tile_memory_write_enable(z_tile), .attribute_memory_write_enable(z_attr),
      .color_memory_write_enable(z_color), .memory_write_addr(z_addr),
      .memory_write_data(z_data), .render_stall(z_stall),
      .pending_count(z_pending), .overflow(z_ovf)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // kind is {tile, attr, color}
   task automatic check_wr(input string tag, input logic [2:0] kind,
                           input logic [11:0] addr, input logic [7:0] data);
      check_val({tag, "_kind"}, {tile_we, attr_we, color_we}, kind);
      check_val({tag, "_addr"}, mem_addr, addr);
      check_val({tag, "_data"}, mem_data, data);
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   logic [15:0] dec_a   [5] = '{16'h07FF, 16'h0800, 16'h17FF, 16'h1800, 16'hFFF3};
   logic [2:0]  dec_k   [5] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
   logic [11:0] dec_x   [5] = '{12'h7FF, 12'h000, 12'hFFF, 12'h000, 12'h003};
   logic [15:0] blk_a   [3] = '{16'h0001, 16'h0802, 16'h1805};
   logic [2:0]  blk_k   [3] = '{3'b100, 3'b010, 3'b001};
   logic [11:0] blk_x   [3] = '{12'h001, 12'h002, 12'h005};
   logic [15:0] ovf_a   [5] = '{16'h0100, 16'h0900, 16'h190A, 16'h0200, 16'h0300};
   logic [2:0]  ovf_k   [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
   logic [11:0] ovf_x   [4] = '{12'h100, 12'h100, 12'h00A, 12'h200};
   logic [15:0] frc_a   [4] = '{16'h0000, 16'h0801, 16'h1802, 16'h0003};

   initial begin
      // ---- reset values ----
      #1 rst = 1'b1;
      #1;
      check_val("rst_strobes", {tile_we, attr_we, color_we}, 3'b000);
      check_val("rst_addr", mem_addr, 12'h000);
      check_val("rst_data", mem_data, 8'h00);
      check_val("rst_stall", render_stall, 1'b0);
      check_val("rst_overflow", overflow, 1'b0);
      check_val("rst_pending", pending, 5'd0);
      check_val("rst_ready", wr_ready, 1'b1);
      tick();
      rst = 1'b0;
      tick();

      // ---- decode, one write per cycle with push and pop at the same edge ----
      render_active = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_addr  = dec_a[i];
         wr_data  = 8'h10 + 8'(i);
         tick();
         if (i == 0)
            check_val("no_bypass", {tile_we, attr_we, color_we}, 3'b000);
         else
            check_wr($sformatf("dec%0d", i - 1), dec_k[i-1], dec_x[i-1], 8'h10 + 8'(i - 1));
         check_val($sformatf("dec_pending%0d", i), pending, 5'd1);
      end
      wr_valid = 1'b0;
      tick();
      check_wr("dec4", dec_k[4], dec_x[4], 8'h14);
      check_val("dec_pending_end", pending, 5'd0);
      tick();
      check_val("dec_idle", {tile_we, attr_we, color_we}, 3'b000);

      // ---- blocking and release ----
      render_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(blk_a[i], 8'h20 + 8'(i));
         check_val($sformatf("blk_quiet%0d", i), {tile_we, attr_we, color_we}, 3'b000);
      end
      tick();
      check_val("blk_pending", pending, 5'd3);
      render_active = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr($sformatf("rel%0d", i), blk_k[i], blk_x[i], 8'h20 + 8'(i));
         check_val($sformatf("rel_pending%0d", i), pending, 5'(2 - i));
      end
      tick();
      check_val("rel_idle", {tile_we, attr_we, color_we}, 3'b000);

      // ---- overflow ----
      render_active = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(ovf_a[i], 8'h30 + 8'(i));
         if (i == 3) begin
            check_val("ovf_ready_low", wr_ready, 1'b0);
            check_val("ovf_not_yet", overflow, 1'b0);
         end
      end
      check_val("ovf_set", overflow, 1'b1);
      check_val("ovf_pending", pending, 5'd4);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check_val("ovf_clear", overflow, 1'b0);
      clear_overflow = 1'b1;
      push(16'h0400, 8'h3F);
      clear_overflow = 1'b0;
      check_val("ovf_set_wins", overflow, 1'b1);
      check_val("ovf_pending2", pending, 5'd4);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check_val("ovf_clear2", overflow, 1'b0);
      render_active = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_wr($sformatf("drain%0d", i), ovf_k[i], ovf_x[i], 8'h30 + 8'(i));
      end
      tick();
      check_val("drain_idle", {tile_we, attr_we, color_we}, 3'b000);
      check_val("drain_pending", pending, 5'd0);

      // ---- forced grant (MAX_WAIT 8) and no forcing (MAX_WAIT 0) ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      render_active = 1'b1;
      for (int i = 0; i < 4; i++)
         push(frc_a[i], 8'h40 + 8'(i));
      check_val("frc_full", pending, 5'd4);
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k < 9)
            check_val($sformatf("frc_wait%0d", k), {tile_we, attr_we, color_we, render_stall}, 4'b0000);
         check_val($sformatf("z_quiet%0d", k), {z_tile, z_attr, z_color, z_stall, z_ready}, 5'b00000);
         check_val($sformatf("z_pending%0d", k), z_pending, 5'd4);
      end
      check_wr("frc", 3'b100, 12'h000, 8'h40);
      check_val("frc_stall", render_stall, 1'b1);
      check_val("frc_pending", pending, 5'd3);
      tick();
      check_val("frc_after", {tile_we, attr_we, color_we, render_stall}, 4'b0000);
      check_val("frc_after_pending", pending, 5'd3);
      check_val("z_after", {z_tile, z_attr, z_color, z_stall}, 4'b0000);
      check_val("z_outputs", {z_addr, z_data, z_ovf}, 21'h0);

      // ---- reset mid-stream ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      render_active = 1'b1;
      for (int i = 0; i < 4; i++)
         push(16'h0010 + 16'(i), 8'h50 + 8'(i));
      render_active = 1'b0;
      tick();
      check_wr("mid_first", 3'b100, 12'h010, 8'h50);
      check_val("mid_pending", pending, 5'd3);
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_strobe", {tile_we, attr_we, color_we}, 3'b000);
      check_val("mid_rst_pending", pending, 5'd0);
      check_val("mid_rst_ready", wr_ready, 1'b1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val($sformatf("post_rst_quiet%0d", i), {tile_we, attr_we, color_we}, 3'b000);
         check_val($sformatf("post_rst_pending%0d", i), pending, 5'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
